// File: rtl/apb_pwm_pkg.sv
// +----------------------------------------------------------------------------+
// | apb_pwm_pkg: register map and shared constants for apb_pwm_multi.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package apb_pwm_pkg;

    localparam int OFF_GEN      = 'h00;
    localparam int OFF_IRQ_STAT = 'h04;
    localparam int OFF_IRQ_MASK = 'h08;

    localparam int CH_BASE      = 'h10;
    localparam int CH_STRIDE    = 'h10;
    localparam int OFF_PERIOD   = 'h0;
    localparam int OFF_DUTY     = 'h4;
    localparam int OFF_CTRL     = 'h8;
    localparam int OFF_CNT      = 'hC;

    localparam int CTRL_POL     = 0;
    localparam int MAX_CH       = 8;

    function automatic int ch_reg_addr(input int ch, input int off);
        return CH_BASE + CH_STRIDE * ch + off;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_pwm_multi_channel.sv
// +----------------------------------------------------------------------------+
// | pwm_channel: one PWM counter with shadowed period/duty and wrap pulse.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             apb_pclk,
    input  logic             apb_prstn,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_sh,
    input  logic [CNT_W-1:0] duty_sh,
    input  logic             pol,
    output logic             pwm,
    output logic             wrap,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] period_a;
    logic [CNT_W-1:0] duty_a;
    logic             run;

    assign wrap = enable & run & (period_a != '0) & (cnt == period_a - CNT_W'(1));

    // The first enabled edge only arms the channel, so phase 0 reaches the pin two edges after GEN.
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            run      <= 1'b0;
            cnt      <= '0;
            period_a <= '0;
            duty_a   <= '0;
            pwm      <= 1'b0;
        end else begin
            run <= enable;
            if (!enable || !run || (period_a == '0)) begin
                cnt      <= '0;
                period_a <= period_sh;
                duty_a   <= duty_sh;
                pwm      <= pol;
            end else begin
                pwm <= (cnt < duty_a) ^ pol;
                if (wrap) begin
                    cnt      <= '0;
                    period_a <= period_sh;
                    duty_a   <= duty_sh;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_pwm_multi.sv
// +----------------------------------------------------------------------------+
// | apb_pwm_multi: multi-channel APB PWM with shadowed period/duty and IRQ.    |
// | Optional IRQ block: define APB_PWM_MULTI_IRQ_EN.   Rev 1.0                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module apb_pwm_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              apb_pclk,
    input  logic              apb_prstn,
    input  logic              apb_psel,
    input  logic              apb_penable,
    input  logic              apb_pwrite,
    input  logic [ADDR_W-1:0] apb_paddr,
    input  logic [DATA_W-1:0] apb_pwdata,
    output logic [DATA_W-1:0] apb_prdata,
    output logic              apb_pready,
    output logic              apb_pslverr,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq
);
    import apb_pwm_pkg::*;

    logic [NUM_CH-1:0] gen;
    logic [NUM_CH-1:0] pol;
    logic [CNT_W-1:0]  period_sh [NUM_CH];
    logic [CNT_W-1:0]  duty_sh   [NUM_CH];
    logic [CNT_W-1:0]  cnt       [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] irq_stat;
    logic [NUM_CH-1:0] irq_mask;

    logic              access;
    logic              wr_en;
    logic              mapped;
    logic [DATA_W-1:0] rdata;
    logic              sel_gen, sel_stat, sel_mask;
    logic [NUM_CH-1:0] sel_per, sel_duty, sel_ctrl;

    assign access      = apb_psel & apb_penable;
    assign wr_en       = access & apb_pwrite;
    assign apb_pready  = 1'b1;
    assign apb_prdata  = (access && mapped) ? rdata : '0;
    assign apb_pslverr = access & ~mapped;

    always_comb begin
        mapped   = 1'b0;
        rdata    = '0;
        sel_gen  = 1'b0;
        sel_stat = 1'b0;
        sel_mask = 1'b0;
        sel_per  = '0;
        sel_duty = '0;
        sel_ctrl = '0;
        if (apb_paddr == ADDR_W'(OFF_GEN)) begin
            mapped = 1'b1; sel_gen = 1'b1; rdata = DATA_W'(gen);
        end
        if (apb_paddr == ADDR_W'(OFF_IRQ_STAT)) begin
            mapped = 1'b1; sel_stat = 1'b1; rdata = DATA_W'(irq_stat);
        end
        if (apb_paddr == ADDR_W'(OFF_IRQ_MASK)) begin
            mapped = 1'b1; sel_mask = 1'b1; rdata = DATA_W'(irq_mask);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (apb_paddr == ADDR_W'(ch_reg_addr(i, OFF_PERIOD))) begin
                mapped = 1'b1; sel_per[i] = 1'b1; rdata = DATA_W'(period_sh[i]);
            end
            if (apb_paddr == ADDR_W'(ch_reg_addr(i, OFF_DUTY))) begin
                mapped = 1'b1; sel_duty[i] = 1'b1; rdata = DATA_W'(duty_sh[i]);
            end
            if (apb_paddr == ADDR_W'(ch_reg_addr(i, OFF_CTRL))) begin
                mapped = 1'b1; sel_ctrl[i] = 1'b1; rdata = DATA_W'(pol[i]);
            end
            if (apb_paddr == ADDR_W'(ch_reg_addr(i, OFF_CNT))) begin
                mapped = 1'b1; rdata = DATA_W'(cnt[i]);
            end
        end
    end

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            gen <= '0;
            pol <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_sh[i] <= '0;
                duty_sh[i]   <= '0;
            end
        end else if (wr_en) begin
            if (sel_gen) gen <= apb_pwdata[NUM_CH-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_per[i])  period_sh[i] <= apb_pwdata[CNT_W-1:0];
                if (sel_duty[i]) duty_sh[i]   <= apb_pwdata[CNT_W-1:0];
                if (sel_ctrl[i]) pol[i]       <= apb_pwdata[CTRL_POL];
            end
        end
    end

`ifdef APB_PWM_MULTI_IRQ_EN
    // A wrap on the same edge as a write-1-to-clear keeps the bit set.
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            irq_stat <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~({NUM_CH{wr_en & sel_stat}} & apb_pwdata[NUM_CH-1:0])) | wrap;
            if (wr_en && sel_mask) irq_mask <= apb_pwdata[NUM_CH-1:0];
            irq <= |(irq_stat & irq_mask);
        end
    end
`else
    assign irq_stat = '0;
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{apb_pwdata, wrap, sel_stat, sel_mask};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .apb_pclk  (apb_pclk),
            .apb_prstn (apb_prstn),
            .enable    (gen[i]),
            .period_sh (period_sh[i]),
            .duty_sh   (duty_sh[i]),
            .pol       (pol[i]),
            .pwm       (pwm_o[i]),
            .wrap      (wrap[i]),
            .cnt       (cnt[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_pwm_multi.sv
// +----------------------------------------------------------------------------+
// | tb_apb_pwm_multi: randomized APB stimulus against a time-based PWM model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_apb_pwm_multi;

    localparam int NUM_CH = 4;
`ifdef APB_PWM_MULTI_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]        paddr = '0;
    logic [31:0]       pwdata = '0;
    logic [31:0]       prdata;
    logic              pready, pslverr, irq;
    logic [NUM_CH-1:0] pwm_o;

    apb_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(16), .ADDR_W(8), .DATA_W(32)) dut (
        .apb_pclk(clk), .apb_prstn(rstn), .apb_psel(psel), .apb_penable(penable),
        .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_prdata(prdata),
        .apb_pready(pready), .apb_pslverr(pslverr), .pwm_o(pwm_o), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each running channel is a sequence of periods; seg_start is the edge at
    // which the output shows phase 0 of the current period.
    int                cyc;
    logic [NUM_CH-1:0] m_gen, m_pol, m_stat, m_mask;
    int                m_per [NUM_CH], m_duty [NUM_CH];
    bit                m_run [NUM_CH];
    int                m_seg_start [NUM_CH], m_segp [NUM_CH], m_segd [NUM_CH];
    logic [NUM_CH-1:0] e_pwm;
    int                e_cnt [NUM_CH];
    logic              e_irq;

    task automatic model_reset();
        cyc = 0; m_gen = '0; m_pol = '0; m_stat = '0; m_mask = '0; e_pwm = '0; e_irq = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_per[i] = 0; m_duty[i] = 0; m_run[i] = 0;
            m_seg_start[i] = 0; m_segp[i] = 0; m_segd[i] = 0; e_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] wraps, w1c;
        int a, ch, off, ph;
        wraps = '0; w1c = '0;
        cyc++;
        e_irq = IRQ_EN && ((m_stat & m_mask) != '0);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!m_gen[i]) begin
                m_run[i] = 0; e_pwm[i] = m_pol[i]; e_cnt[i] = 0;
            end else if (!m_run[i] || m_segp[i] == 0) begin
                m_run[i] = 1; m_seg_start[i] = cyc + 1;
                m_segp[i] = m_per[i]; m_segd[i] = m_duty[i];
                e_pwm[i] = m_pol[i]; e_cnt[i] = 0;
            end else begin
                ph = cyc - m_seg_start[i];
                e_pwm[i] = (ph < m_segd[i]) ^ m_pol[i];
                if (ph == m_segp[i] - 1) begin
                    wraps[i] = 1'b1; m_seg_start[i] = cyc + 1;
                    m_segp[i] = m_per[i]; m_segd[i] = m_duty[i]; e_cnt[i] = 0;
                end else begin
                    e_cnt[i] = ph + 1;
                end
            end
        end
        if (psel && penable && pwrite) begin
            a = int'(paddr); ch = a / 16 - 1; off = a % 16;
            if (a == 0) m_gen = pwdata[NUM_CH-1:0];
            else if (a == 4) w1c = pwdata[NUM_CH-1:0];
            else if (a == 8) m_mask = IRQ_EN ? pwdata[NUM_CH-1:0] : '0;
            else if (a >= 16 && ch < NUM_CH) begin
                if (off == 0) m_per[ch] = int'(pwdata[15:0]);
                else if (off == 4) m_duty[ch] = int'(pwdata[15:0]);
                else if (off == 8) m_pol[ch] = pwdata[0];
            end
        end
        if (IRQ_EN) m_stat = (m_stat & ~w1c) | wraps;
    endtask

    task automatic model_read(input int a, output logic [31:0] d, output logic e);
        int ch, off;
        d = '0; e = 1'b1;
        ch = a / 16 - 1; off = a % 16;
        if (a == 0) begin e = 1'b0; d = 32'(m_gen); end
        else if (a == 4) begin e = 1'b0; d = 32'(m_stat); end
        else if (a == 8) begin e = 1'b0; d = 32'(m_mask); end
        else if (a >= 16 && ch < NUM_CH && off % 4 == 0) begin
            e = 1'b0;
            if (off == 0) d = 32'(m_per[ch]);
            else if (off == 4) d = 32'(m_duty[ch]);
            else if (off == 8) d = 32'(m_pol[ch]);
            else d = 32'(e_cnt[ch]);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("pwm_o", 32'(pwm_o), 32'(e_pwm));
            check("irq", 32'(irq), 32'(e_irq));
            check("pready", 32'(pready), 32'd1);
        end
    end

    task automatic apb_write(input int addr, input logic [31:0] data);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'(addr); pwdata = data;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input int addr);
        logic [31:0] ed;
        logic        ee;
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'(addr);
        @(negedge clk); penable = 1'b1;
        #1;
        model_read(addr, ed, ee);
        check($sformatf("rdata@%02h", addr), prdata, ed);
        check($sformatf("slverr@%02h", addr), 32'(pslverr), 32'(ee));
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic read_all();
        apb_rd(0); apb_rd(4); apb_rd(8);
        for (int c = 0; c < NUM_CH; c++)
            for (int o = 0; o < 16; o += 4) apb_rd(16 + 16 * c + o);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        read_all();

        // ch0 P=10 D=3, then a duty change mid-period
        apb_write('h10, 10); apb_write('h14, 3); apb_write('h00, 1);
        for (int k = 0; k < 6; k++) apb_rd('h1C);
        apb_write('h14, 7);
        repeat (30) @(negedge clk);

        // ch1 inverted polarity through 0% and 100% duty, then disabled
        apb_write('h28, 1); apb_write('h20, 10); apb_write('h24, 0); apb_write('h00, 3);
        repeat (15) @(negedge clk);
        apb_write('h24, 12);
        repeat (25) @(negedge clk);
        apb_write('h00, 1);
        repeat (5) @(negedge clk);

        // wrap interrupt, W1C colliding with a wrap at P=1
        apb_write('h08, 1); apb_write('h10, 4);
        repeat (12) @(negedge clk);
        apb_rd('h04); apb_write('h04, 1); apb_rd('h04);
        apb_write('h10, 1);
        repeat (6) @(negedge clk);
        apb_write('h04, 1); apb_rd('h04);

        // unmapped accesses and a zero period
        apb_rd('h50); apb_write('h50, 32'hFFFF); apb_rd('h0C); apb_write('h0C, 32'h5);
        apb_rd('h11); apb_write('h04, 32'hF); apb_write('h10, 0);
        repeat (10) @(negedge clk);
        read_all();

        for (int it = 0; it < 80; it++) begin
            int c, k;
            c = int'($urandom_range(0, NUM_CH - 1));
            k = int'($urandom_range(0, 7));
            case (k)
                0: apb_write(16 + 16 * c, $urandom_range(0, 12));
                1: apb_write(20 + 16 * c, $urandom_range(0, 14));
                2: apb_write(24 + 16 * c, $urandom);
                3: apb_write(0, $urandom);
                4: apb_write(8, $urandom);
                5: apb_write(4, $urandom);
                6: apb_write(int'($urandom_range(0, 255)), $urandom_range(0, 15));
                default: apb_rd(int'($urandom_range(0, 255)));
            endcase
            repeat ($urandom_range(0, 15)) @(negedge clk);
            apb_rd(28 + 16 * c);
        end

        // asynchronous reset while channels run
        @(negedge clk); #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        read_all();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
